// File: rtl/mseq_pkg.sv
// Shared constants, state type and LFSR step helper for the M-sequence generator bank.
package mseq_pkg;

    localparam int LFSR_W    = 32;
    localparam int GEN_COUNT = 4;
    localparam int DIN_W     = 9 * LFSR_W;

    localparam logic [LFSR_W-1:0] SALT [GEN_COUNT] = '{
        32'h0000_0000, 32'h9E37_79B9, 32'h7F4A_7C15, 32'hF39C_C060
    };

    localparam int TAPS [4] = '{31, 21, 1, 0};

    localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 32'h0000_0001;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Fibonacci step for x^32 + x^22 + x^2 + x + 1
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fb ^= s[TAPS[i]];
        end
        return {s[LFSR_W-2:0], fb};
    endfunction

endpackage

// File: rtl/mseq_gen_bank_if.sv
// Seed-update input bus and 4-bit output stream of the generator bank.
interface mseq_gen_bank_if;
    import mseq_pkg::*;

    logic [DIN_W-1:0]     MSEQ_din;
    logic [GEN_COUNT-1:0] MSEQ_din_valid;
    logic                 out_ready;
    logic                 out_valid;
    logic [GEN_COUNT-1:0] out_data;
    logic [GEN_COUNT-1:0] seeded;
    logic [15:0]          seed_count;

    modport master (
        output MSEQ_din, MSEQ_din_valid, out_ready,
        input  out_valid, out_data, seeded, seed_count
    );

    modport slave (
        input  MSEQ_din, MSEQ_din_valid, out_ready,
        output out_valid, out_data, seeded, seed_count
    );

endinterface

// File: rtl/mseq_lfsr32.sv
// One 32-bit maximal-length LFSR with a pending-seed slot that holds a reseed
// arriving while the output stream is stalled.
module mseq_lfsr32
    import mseq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    input  logic              stall,
    output logic              msb
);

    logic [LFSR_W-1:0] lfsr_reg, lfsr_next;
    logic [LFSR_W-1:0] pending_reg, pending_next;
    logic              pend_reg, pend_next;
    logic [LFSR_W-1:0] seed_safe;

    // An all-zero state would lock the LFSR up forever
    assign seed_safe = (seed == '0) ? ZERO_SEED_SUB : seed;

    always_comb begin
        lfsr_next    = lfsr_reg;
        pending_next = pending_reg;
        pend_next    = pend_reg;
        if (load && stall) begin
            pending_next = seed_safe;
            pend_next    = 1'b1;
        end else if (load) begin
            // Direct load replaces the step and supersedes any older pending seed
            lfsr_next = seed_safe;
            pend_next = 1'b0;
        end else if (step) begin
            if (pend_reg) begin
                lfsr_next = pending_reg;
                pend_next = 1'b0;
            end else begin
                lfsr_next = lfsr_step(lfsr_reg);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg    <= '0;
            pending_reg <= '0;
            pend_reg    <= 1'b0;
        end else begin
            lfsr_reg    <= lfsr_next;
            pending_reg <= pending_next;
            pend_reg    <= pend_next;
        end
    end

    assign msb = lfsr_reg[LFSR_W-1];

endmodule

// File: rtl/mseq_gen_bank.sv
// Bank of four reseedable LFSR generators streaming one bit per generator per
// cycle once every generator has been seeded.
module mseq_gen_bank
    import mseq_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = DIN_W,
    parameter int NUM_GEN          = GEN_COUNT
)
(
    input  logic           clk,
    input  logic           rst_n,
    mseq_gen_bank_if.slave bus
);

    localparam int FOLD_WORDS = INPUT_DATA_WIDTH / LFSR_W;

    state_t              state_reg, state_next;
    logic [NUM_GEN-1:0]  seeded_reg, seeded_next;
    logic [15:0]         seed_count_reg, seed_count_next;
    logic [15:0]         load_count;
    logic [LFSR_W-1:0]   seed_raw;
    logic [NUM_GEN-1:0]  msb;
    logic                out_valid;
    logic                stall;
    logic                fire;

    always_comb begin
        seed_raw = '0;
        for (int i = 0; i < FOLD_WORDS; i++) begin
            seed_raw ^= bus.MSEQ_din[i*LFSR_W +: LFSR_W];
        end
    end

    always_comb begin
        load_count = '0;
        for (int i = 0; i < NUM_GEN; i++) begin
            load_count += 16'(bus.MSEQ_din_valid[i]);
        end
    end

    assign out_valid       = (state_reg == RUN);
    assign stall           = out_valid & ~bus.out_ready;
    assign fire            = out_valid & bus.out_ready;
    assign seeded_next     = seeded_reg | bus.MSEQ_din_valid;
    assign seed_count_next = seed_count_reg + load_count;

    // Leave FILL on the same edge that loads the last unseeded generator
    always_comb begin
        state_next = state_reg;
        if (state_reg == FILL && seeded_next == '1) begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= FILL;
            seeded_reg     <= '0;
            seed_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            seeded_reg     <= seeded_next;
            seed_count_reg <= seed_count_next;
        end
    end

    for (genvar gi = 0; gi < NUM_GEN; gi++) begin : g_gen
        mseq_lfsr32 u_lfsr (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (bus.MSEQ_din_valid[gi]),
            .seed  (seed_raw ^ SALT[gi]),
            .step  (fire),
            .stall (stall),
            .msb   (msb[gi])
        );
    end

    assign bus.out_valid  = out_valid;
    assign bus.out_data   = msb;
    assign bus.seeded     = seeded_reg;
    assign bus.seed_count = seed_count_reg;

endmodule
